// File: rtl/cpu_sequencer.sv
// Multi-cycle sequencer owning PC and IR, arbitrating the shared memory port between fetch and load/store.
// Optional memory-wait timeout, enabled by defining CPU_SEQUENCER_TIMEOUT_EN.
module cpu_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_write_en,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_length,
    input  logic [31:0] mem_rdata,
    input  logic        dec_mem_read,
    input  logic        dec_mem_write,
    input  logic        dec_reg_write,
    input  logic        dec_branch,
    input  logic [2:0]  dec_mem_op_length,
    input  logic [31:0] dec_immediate,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        reg_write,
    output logic [31:0] wb_data,
    output logic [2:0]  state,
    output logic        fault
);

    localparam int unsigned XLEN      = 32;
    localparam int unsigned LEN_W     = 3;
    localparam logic [XLEN-1:0]  NOP_INSTR = 32'h0000_0013;
    localparam logic [LEN_W-1:0] LEN_WORD  = 3'b010;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_FAULT     = 3'd7
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] load_q, load_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] pc_sum_c;
    logic            timeout_c;

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_FETCH;
            pc_q     <= {RESET_PC[XLEN-1:2], 2'b00};
            instr_q  <= NOP_INSTR;
            result_q <= '0;
            load_q   <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            result_q <= result_d;
            load_q   <= load_d;
            fault_q  <= fault_d;
        end
    end

    assign pc_sum_c = (dec_branch && alu_zero) ? (pc_q + dec_immediate) : (pc_q + XLEN'(4));

    // Next-state and register update logic
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        result_d = result_q;
        load_d   = load_q;
        fault_d  = fault_q;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready) begin
                    instr_d = mem_rdata;
                    state_d = ST_DECODE;
                end else if (timeout_c) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                result_d = alu_result;
                if (dec_mem_read && dec_mem_write) begin
                    state_d = ST_FAULT;
                end else if (dec_mem_read || dec_mem_write) begin
                    state_d = ST_MEMORY;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_MEMORY: begin
                if (mem_ready) begin
                    if (dec_mem_read) begin
                        load_d = mem_rdata;
                    end
                    state_d = ST_WRITEBACK;
                end else if (timeout_c) begin
                    state_d = ST_FAULT;
                end
            end
            ST_WRITEBACK: begin
                pc_d    = {pc_sum_c[XLEN-1:2], 2'b00};
                state_d = ST_FETCH;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
        if (state_d == ST_FAULT) begin
            fault_d = 1'b1;
        end
    end

    // Memory port and writeback decode; reset gates requests in the reset cycle itself
    always_comb begin
        mem_valid    = 1'b0;
        mem_write_en = 1'b0;
        mem_addr     = '0;
        mem_length   = '0;
        reg_write    = 1'b0;
        wb_data      = '0;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    mem_valid  = 1'b1;
                    mem_addr   = pc_q;
                    mem_length = LEN_WORD;
                end
                ST_MEMORY: begin
                    mem_valid    = 1'b1;
                    mem_addr     = result_q;
                    mem_write_en = dec_mem_write;
                    mem_length   = dec_mem_op_length;
                end
                ST_WRITEBACK: begin
                    reg_write = dec_reg_write;
                    wb_data   = dec_mem_read ? load_q : result_q;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CPU_SEQUENCER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(MEM_TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Wait-cycle counter, restarted whenever a new request phase is entered
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (mem_valid && !mem_ready) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
        if ((state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEMORY))) begin
            to_cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign timeout_c = (to_cnt_q == TO_W'(MEM_TIMEOUT - 1));
`else
    assign timeout_c = 1'b0;
`endif

    assign pc          = pc_q;
    assign instruction = instr_q;
    assign state       = 3'(state_q);
    assign fault       = fault_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed scoreboard bench for cpu_sequencer: a cycle-level memory model answers requests,
// expected requests and writebacks are queued at issue time and popped as the DUT produces them.
module tb_cpu_sequencer;

    localparam logic [31:0] RESET_PC    = 32'h0000_0100;
    localparam int unsigned MEM_TIMEOUT = 16;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [2:0]  len;
    } req_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_write_en;
    logic [31:0] mem_addr;
    logic [2:0]  mem_length;
    logic [31:0] mem_rdata;
    logic        dec_mem_read;
    logic        dec_mem_write;
    logic        dec_reg_write;
    logic        dec_branch;
    logic [2:0]  dec_mem_op_length;
    logic [31:0] dec_immediate;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        reg_write;
    logic [31:0] wb_data;
    logic [2:0]  state;
    logic        fault;

    int          checks = 0;
    int          errors = 0;
    req_t        exp_req_q[$];
    logic [31:0] exp_wb_q[$];
    int          fetch_wait = 0;
    int          data_wait  = 0;
    int          wait_cnt   = 0;
    int          pulses     = 0;
    logic        spurious   = 1'b0;
    logic [31:0] pc_m;

    always #5 clock = ~clock;

    cpu_sequencer #(
        .RESET_PC   (RESET_PC),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .pc               (pc),
        .instruction      (instruction),
        .mem_valid        (mem_valid),
        .mem_ready        (mem_ready),
        .mem_write_en     (mem_write_en),
        .mem_addr         (mem_addr),
        .mem_length       (mem_length),
        .mem_rdata        (mem_rdata),
        .dec_mem_read     (dec_mem_read),
        .dec_mem_write    (dec_mem_write),
        .dec_reg_write    (dec_reg_write),
        .dec_branch       (dec_branch),
        .dec_mem_op_length(dec_mem_op_length),
        .dec_immediate    (dec_immediate),
        .alu_result       (alu_result),
        .alu_zero         (alu_zero),
        .reg_write        (reg_write),
        .wb_data          (wb_data),
        .state            (state),
        .fault            (fault)
    );

    function automatic logic [31:0] rdfn(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h1234_5678;
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of the memory model plus scoreboard checks; entered just after a falling edge
    task automatic step();
        int need;
        if (mem_valid) begin
            need = (state == 3'd0) ? fetch_wait : data_wait;
            checks++;
            assert (exp_req_q.size() != 0) else begin
                errors++;
                $error("FAIL req_pending observed=unexpected_request addr=%h expected=no_request", mem_addr);
            end
            if (exp_req_q.size() != 0) begin
                chk("mem_addr", mem_addr, exp_req_q[0].addr);
                chk("mem_write_en", 32'(mem_write_en), 32'(exp_req_q[0].we));
                chk("mem_length", 32'(mem_length), 32'(exp_req_q[0].len));
            end
            if (wait_cnt >= need) begin
                mem_ready = 1'b1;
                mem_rdata = rdfn(mem_addr);
                if (exp_req_q.size() != 0) void'(exp_req_q.pop_front());
                wait_cnt = 0;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 32'hBAD0_BAD0;
                wait_cnt++;
            end
        end else begin
            mem_ready = spurious;
            mem_rdata = 32'hDEAD_0000;
        end
        if (reg_write) begin
            pulses++;
            checks++;
            assert (exp_wb_q.size() != 0) else begin
                errors++;
                $error("FAIL wb_pending observed=unexpected_reg_write data=%h expected=none", wb_data);
            end
            if (exp_wb_q.size() != 0) chk("wb_data", wb_data, exp_wb_q.pop_front());
        end
        @(negedge clock);
    endtask

    task automatic run_instr(input string tag, input logic [31:0] alu_res, input logic rd, input logic wr,
                             input logic rw, input logic br, input logic zero, input logic [2:0] len,
                             input logic [31:0] imm, input int fw, input int dw, input int exp_cycles);
        req_t        r;
        logic [31:0] exp_instr;
        logic [31:0] sum;
        logic [31:0] next_pc;
        int          cycles;
        bit          done;
        r.addr = pc_m;
        r.we   = 1'b0;
        r.len  = 3'b010;
        exp_req_q.push_back(r);
        if (rd || wr) begin
            r.addr = alu_res;
            r.we   = wr;
            r.len  = len;
            exp_req_q.push_back(r);
        end
        if (rw) exp_wb_q.push_back(rd ? rdfn(alu_res) : alu_res);
        exp_instr = rdfn(pc_m);
        sum       = (br && zero) ? (pc_m + imm) : (pc_m + 32'd4);
        next_pc   = {sum[31:2], 2'b00};
        dec_mem_read      = rd;
        dec_mem_write     = wr;
        dec_reg_write     = rw;
        dec_branch        = br;
        dec_mem_op_length = len;
        dec_immediate     = imm;
        alu_result        = alu_res;
        alu_zero          = zero;
        fetch_wait = fw;
        data_wait  = dw;
        wait_cnt   = 0;
        pulses     = 0;
        cycles     = 0;
        done       = 1'b0;
        while (!done && cycles < 64) begin
            if (state == 3'd4) done = 1'b1;
            cycles++;
            step();
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_cycles"}, 32'(cycles), 32'(exp_cycles));
        chk({tag, "_reg_write_pulses"}, 32'(pulses), 32'(rw));
        chk({tag, "_next_pc"}, pc, next_pc);
        chk({tag, "_instruction"}, instruction, exp_instr);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_sb_drained"}, 32'(exp_req_q.size() + exp_wb_q.size()), 32'd0);
        pc_m = next_pc;
    endtask

    initial begin
        req_t r;
        reset             = 1'b1;
        mem_ready         = 1'b1;
        mem_rdata         = 32'h0;
        dec_mem_read      = 1'b0;
        dec_mem_write     = 1'b0;
        dec_reg_write     = 1'b0;
        dec_branch        = 1'b0;
        dec_mem_op_length = 3'b000;
        dec_immediate     = 32'h0;
        alu_result        = 32'h0;
        alu_zero          = 1'b0;
        pc_m              = RESET_PC;

        // Reset state, with mem_ready held high throughout
        repeat (2) @(negedge clock);
        chk("rst_pc", pc, RESET_PC);
        chk("rst_instruction", instruction, 32'h0000_0013);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        reset     = 1'b0;
        mem_ready = 1'b0;
        #1;

        run_instr("alu", 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 0, 0, 4);
        spurious = 1'b1;
        run_instr("load", 32'h0000_0040, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 32'h0, 0, 3, 8);
        spurious = 1'b0;
        run_instr("store", 32'h0000_0080, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 2, 1, 8);
        run_instr("br_to_200", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 32'h0000_00F4, 0, 0, 4);
        chk("pc_is_200", pc, 32'h0000_0200);
        run_instr("br_back", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 32'hFFFF_FFF0, 0, 0, 4);
        chk("pc_is_1f0", pc, 32'h0000_01F0);
        run_instr("br_fwd", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 32'h0000_0010, 0, 0, 4);
        run_instr("br_not_taken", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'hFFFF_FFF0, 0, 0, 4);
        chk("pc_is_204", pc, 32'h0000_0204);
        run_instr("zero_no_branch", 32'h7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0040, 0, 0, 4);
        run_instr("br_to_top", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 32'hFFFF_FDF4, 0, 0, 4);
        chk("pc_is_top", pc, 32'hFFFF_FFFC);
        run_instr("wrap", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 0, 0, 4);
        chk("pc_wrapped", pc, 32'h0000_0000);
        run_instr("br_misaligned", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 32'h0000_0007, 0, 0, 4);
        chk("pc_masked", pc, 32'h0000_0004);

        // Read+write conflict drives the sequencer into FAULT
        r.addr = pc_m;
        r.we   = 1'b0;
        r.len  = 3'b010;
        exp_req_q.push_back(r);
        dec_mem_read  = 1'b1;
        dec_mem_write = 1'b1;
        dec_reg_write = 1'b1;
        fetch_wait    = 0;
        wait_cnt      = 0;
        repeat (3) step();
        chk("conflict_state", 32'(state), 32'd7);
        chk("conflict_fault", 32'(fault), 32'd1);
        spurious = 1'b1;
        repeat (4) begin
            chk("fault_mem_valid", 32'(mem_valid), 32'd0);
            chk("fault_reg_write", 32'(reg_write), 32'd0);
            chk("fault_pc_frozen", pc, pc_m);
            chk("fault_sticky", 32'(fault), 32'd1);
            step();
        end
        spurious = 1'b0;

        // Reset leaves FAULT
        reset     = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("rst2_mem_valid", 32'(mem_valid), 32'd0);
        @(negedge clock);
        chk("rst2_state", 32'(state), 32'd0);
        chk("rst2_fault", 32'(fault), 32'd0);
        chk("rst2_pc", pc, RESET_PC);
        chk("rst2_instruction", instruction, 32'h0000_0013);
        reset     = 1'b0;
        mem_ready = 1'b0;
        exp_req_q.delete();
        exp_wb_q.delete();
        pc_m = RESET_PC;
        #1;
        chk("rst2_fetch_valid", 32'(mem_valid), 32'd1);
        chk("rst2_fetch_addr", mem_addr, RESET_PC);

        // Reset in the middle of a waiting load aborts it
        r.addr = pc_m;
        r.we   = 1'b0;
        r.len  = 3'b010;
        exp_req_q.push_back(r);
        r.addr = 32'h0000_0040;
        r.len  = 3'b001;
        exp_req_q.push_back(r);
        dec_mem_read      = 1'b1;
        dec_mem_write     = 1'b0;
        dec_reg_write     = 1'b1;
        dec_mem_op_length = 3'b001;
        alu_result        = 32'h0000_0040;
        fetch_wait        = 0;
        data_wait         = 20;
        wait_cnt          = 0;
        repeat (5) step();
        chk("abort_in_memory", 32'(state), 32'd3);
        reset     = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        #1;
        chk("abort_mem_valid", 32'(mem_valid), 32'd0);
        @(negedge clock);
        reset     = 1'b0;
        mem_ready = 1'b0;
        exp_req_q.delete();
        exp_wb_q.delete();
        pc_m = RESET_PC;
        #1;
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_pc", pc, RESET_PC);
        chk("abort_instruction", instruction, 32'h0000_0013);
        chk("abort_refetch_addr", mem_addr, RESET_PC);
        run_instr("post_abort", 32'h0000_0055, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 0, 0, 4);

        // Memory never answers a fetch
        mem_ready = 1'b0;
`ifdef CPU_SEQUENCER_TIMEOUT_EN
        repeat (MEM_TIMEOUT) begin
            chk("to_waiting", 32'(state), 32'd0);
            @(negedge clock);
        end
        chk("to_fault_state", 32'(state), 32'd7);
        chk("to_fault_flag", 32'(fault), 32'd1);
        chk("to_mem_valid", 32'(mem_valid), 32'd0);
`else
        repeat (100) @(negedge clock);
        chk("nto_state", 32'(state), 32'd0);
        chk("nto_mem_valid", 32'(mem_valid), 32'd1);
        chk("nto_mem_addr", mem_addr, pc_m);
        chk("nto_fault", 32'(fault), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the CPU datapath. It owns the program counter and the instruction register, and steps each instruction through fetch, decode, execute, memory and writeback. It also shares the single memory port between instruction fetch and load/store traffic over a valid/ready handshake. It sits between `memory` and the `decoder`/`registers`/`alu` datapath, and supplies the register-file write strobe and writeback data.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
- `MEM_TIMEOUT`, 16, maximum cycles to wait for `mem_ready` (used only with the timeout feature)

Ports:
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high
- `pc`  out  32  current program counter
- `instruction`  out  32  latched instruction register; feeds `decoder`
- `mem_valid`  out  1  memory request
- `mem_ready`  in  1  memory completes the request this cycle
- `mem_write_en`  out  1  request is a store
- `mem_addr`  out  32  request address
- `mem_length`  out  3  access length; 3'b010 (word) for fetch
- `mem_rdata`  in  32  read data, valid when `mem_ready`
- `dec_mem_read`, `dec_mem_write`, `dec_reg_write`, `dec_branch`  in  1 each  decoder controls
- `dec_mem_op_length`  in  3  decoder load/store length
- `dec_immediate`  in  32  decoder immediate (branch offset)
- `alu_result`  in  32  ALU result
- `alu_zero`  in  1  ALU zero flag
- `reg_write`  out  1  register-file write strobe
- `wb_data`  out  32  register-file write data
- `state`  out  3  current FSM state, for debug
- `fault`  out  1  sticky fault flag

## Operation
- States and encodings:
  - FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, FAULT=7.
  - Encodings 5 and 6 are unreachable and go to FAULT.
- FETCH:
  - Drives `mem_valid`=1, `mem_addr`=`pc`, `mem_write_en`=0, `mem_length`=3'b010.
  - When `mem_ready` is sampled, latches `mem_rdata` into `instruction` and moves to DECODE.
- DECODE: single cycle so decoder outputs can settle, then EXECUTE.
- EXECUTE:
  - Latches `alu_result` into an internal result register.
  - If both `dec_mem_read` and `dec_mem_write` are set, goes to FAULT.
  - Else if either is set, goes to MEMORY.
  - Else goes to WRITEBACK.
- MEMORY:
  - Drives `mem_valid`=1, `mem_addr`=result register, `mem_write_en`=`dec_mem_write`, `mem_length`=`dec_mem_op_length`.
  - On `mem_ready`, a load latches `mem_rdata` into the load register. Then moves to WRITEBACK.
- WRITEBACK:
  - `reg_write`=`dec_reg_write` for exactly one cycle.
  - `wb_data` = load register after a load, otherwise the result register.
  - `pc` updates to `pc + dec_immediate` if `dec_branch && alu_zero`, otherwise `pc + 4`.
  - Bits [1:0] of the new PC are forced to 0. Arithmetic is modulo 2^32 (wrap from 32'hFFFF_FFFC to 0).
  - Next state is FETCH.
- FAULT:
  - `fault`=1, `mem_valid`=0, `reg_write`=0, `pc` frozen.
  - Only `reset` exits this state.
- Handshake rules:
  - Once `mem_valid` is high, `mem_addr`, `mem_write_en` and `mem_length` stay stable until `mem_ready` is sampled.
  - `mem_ready` while `mem_valid`=0 is ignored.
  - `mem_valid` drops in the cycle after `mem_ready`.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `instruction`=32'h0000_0013 (NOP), `state`=FETCH.
  - `mem_valid`=0 during the reset cycle; it rises in the first cycle after `reset` deasserts.
  - `reg_write`=0, `wb_data`=0, `fault`=0; result and load registers are 0.
- Reset asserted mid-transaction aborts it: `mem_valid` is 0 in the next cycle, and any `mem_ready` in the reset cycle is ignored.
- Latency with zero memory wait:
  - Non-memory instruction: 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK).
  - Load or store: 5 cycles.
  - Each wait cycle on `mem_ready` adds 1 cycle.
- All outputs are registered except `mem_*` and `reg_write`/`wb_data`, which decode from `state` and the registers.

## Configuration
- `CPU_SEQUENCER_TIMEOUT_EN` defined:
  - A counter clears on entry to FETCH or MEMORY and increments each cycle `mem_valid`=1 without `mem_ready`.
  - When it reaches `MEM_TIMEOUT`, the next state is FAULT.
- Not defined:
  - No counter is built; the sequencer waits indefinitely for `mem_ready`.
  - FAULT is reachable only through the read+write conflict or an illegal state.

## Test plan
- Reset with `RESET_PC`=32'h100 and `mem_ready` tied high -> first fetch `mem_addr`=32'h100; `reg_write` pulses in cycle 4; second fetch at 32'h104.
- ALU-type instruction with `alu_result`=32'hDEAD_BEEF and `dec_reg_write`=1 -> `wb_data`=32'hDEAD_BEEF with a single-cycle `reg_write`; no MEMORY state.
- Load: `alu_result`=32'h40, `mem_rdata`=32'h1234_5678, `mem_ready` delayed 3 cycles -> `mem_addr`=32'h40 held stable for 4 cycles; `wb_data`=32'h1234_5678; 8 cycles total.
- Branch taken with `pc`=32'h200, `dec_immediate`=32'hFFFF_FFF0, `alu_zero`=1 -> next fetch at 32'h1F0. Not taken -> 32'h204. `pc`=32'hFFFF_FFFC not taken -> 32'h0.
- Both `dec_mem_read` and `dec_mem_write` high -> `state`=7, `fault`=1, no further `mem_valid`. `reset` -> back to FETCH at `RESET_PC`.
- With `CPU_SEQUENCER_TIMEOUT_EN`, `MEM_TIMEOUT`=16 and `mem_ready` held low -> FAULT after 16 waiting cycles. Without the macro -> still in FETCH after 100 cycles.
